mux_nx1_seq: RTL and testbench

MUX_NX1_SEQ -- requirements
Module: mux_nx1_seq

---
 rtl/mux_pkg.sv | 19 +
 rtl/mux_scan_ctr.sv | 37 +++
 rtl/mux_nx1_seq.sv | 65 ++++++
 tb/tb_mux_nx1_seq.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared defaults, mode encoding and width helper for the N:1 sequential mux
package mux_pkg;

    localparam int N_DEF = 13;
    localparam int W_DEF = 1;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_scan_ctr.sv
// mux_scan_ctr: auto-scan channel counter with restart on mode rise and wrap detect
module mux_scan_ctr
    import mux_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int SW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode,
    input  logic          en,
    output logic [SW-1:0] idx,
    output logic          last
);

    logic [SW-1:0] cnt;
    logic          mode_q;

    // a fresh entry into scan mode presents channel 0 regardless of the stale count
    always_comb begin
        idx  = (mode == MODE_SCAN && mode_q != MODE_SCAN) ? '0 : cnt;
        last = idx == SW'(N - 1);
    end

    // mode history tracks every cycle; the count moves only on enabled scan updates
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode;
            if (en && mode == MODE_SCAN)
                cnt <= last ? '0 : idx + SW'(1);
        end
    end

endmodule

// File: rtl/mux_nx1_seq.sv
// mux_nx1_seq: registered N:1 channel mux with direct select and auto-scan modes
module mux_nx1_seq
    import mux_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int W  = W_DEF,
    parameter int SW = clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N*W-1:0]  i,
    input  logic [SW-1:0]   s,
    input  logic            mode,
    input  logic            en,
    output logic [W-1:0]    o,
    output logic [SW-1:0]   ch,
    output logic            vld,
    output logic            err,
    output logic            wrap
);

    logic [SW-1:0] idx;
    logic [SW-1:0] sel;
    logic          last;
    logic          scan;
    logic          legal;

    mux_scan_ctr #(.N(N), .SW(SW)) u_ctr (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .en   (en),
        .idx  (idx),
        .last (last)
    );

    // scan ignores s; a direct select is legal only when it names an existing channel
    always_comb begin
        scan  = mode == MODE_SCAN;
        sel   = scan ? idx : s;
        legal = scan || (int'(s) < N);
    end

    // output register: sample on enable, otherwise hold data/index and drop the flags
    always_ff @(posedge clk) begin
        if (rst) begin
            o    <= '0;
            ch   <= '0;
            vld  <= 1'b0;
            err  <= 1'b0;
            wrap <= 1'b0;
        end else if (en) begin
            o    <= legal ? i[sel*W +: W] : '0;
            ch   <= sel;
            vld  <= legal;
            err  <= !legal;
            wrap <= scan && last;
        end else begin
            vld  <= 1'b0;
            err  <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nx1_seq.sv
// tb_mux_nx1_seq: directed and randomized checks of mux_nx1_seq against a behavioural model
module tb_mux_nx1_seq;

    localparam logic [12:0] I_REF = 13'b1010011101110;

    logic        clk = 1'b0;
    logic        rst, en, mode;
    logic [3:0]  s;
    logic [12:0] i;
    logic        o;
    logic [3:0]  ch;
    logic        vld, err, wrap;

    logic        rst4, en4, mode4;
    logic [1:0]  s4;
    logic [31:0] i4;
    logic [7:0]  o4;
    logic [1:0]  ch4;
    logic        vld4, err4, wrap4;

    int checks = 0;
    int errors = 0;

    int m_pos  = 0;
    bit m_prev = 0;
    int e_o = 0, e_ch = 0, e_vld = 0, e_err = 0, e_wrap = 0;

    always #5 clk = ~clk;

    mux_nx1_seq u_dut (
        .clk (clk), .rst (rst), .i (i), .s (s), .mode (mode), .en (en),
        .o (o), .ch (ch), .vld (vld), .err (err), .wrap (wrap)
    );

    mux_nx1_seq #(.N(4), .W(8)) u_dut4 (
        .clk (clk), .rst (rst4), .i (i4), .s (s4), .mode (mode4), .en (en4),
        .o (o4), .ch (ch4), .vld (vld4), .err (err4), .wrap (wrap4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock of the 13-channel DUT: drive, advance the model, compare every output
    task automatic step(input bit r, input bit e, input bit m, input int sel, input logic [12:0] data);
        int p;
        rst = r; en = e; mode = m; s = sel[3:0]; i = data;
        @(posedge clk);
        if (r) begin
            m_pos = 0; m_prev = 0;
            e_o = 0; e_ch = 0; e_vld = 0; e_err = 0; e_wrap = 0;
        end else begin
            if (e) begin
                if (m) begin
                    p      = m_prev ? m_pos : 0;
                    e_o    = int'(data[p]);
                    e_ch   = p;
                    e_vld  = 1;
                    e_err  = 0;
                    e_wrap = (p == 12) ? 1 : 0;
                    m_pos  = (p + 1) % 13;
                end else begin
                    e_ch   = sel % 16;
                    e_vld  = (e_ch < 13) ? 1 : 0;
                    e_err  = 1 - e_vld;
                    e_o    = e_vld ? int'(data[e_ch]) : 0;
                    e_wrap = 0;
                end
            end else begin
                e_vld = 0; e_err = 0; e_wrap = 0;
            end
            m_prev = m;
        end
        #1;
        check("o", o, e_o);
        check("ch", ch, e_ch);
        check("vld", vld, e_vld);
        check("err", err, e_err);
        check("wrap", wrap, e_wrap);
    endtask

    task automatic step4(input bit r, input bit e, input bit m, input int sel);
        rst4 = r; en4 = e; mode4 = m; s4 = sel[1:0];
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit sweep_exp [13] = '{0,1,1,1,0,1,1,1,0,0,1,0,1};
        bit r, e, m;
        rst4 = 1'b1; en4 = 1'b0; mode4 = 1'b0; s4 = '0; i4 = 32'hDDCCBBAA;

        step(1, 1, 1, 5, I_REF);
        check("reset_o", o, 0);
        check("reset_ch", ch, 0);

        for (int k = 0; k < 16; k++) begin
            step(0, 1, 0, k, I_REF);
            if (k < 13) check("sweep_o", o, sweep_exp[k]);
            else begin
                check("sweep_hi_o", o, 0);
                check("sweep_hi_err", err, 1);
                check("sweep_hi_vld", vld, 0);
            end
        end

        for (int k = 0; k < 28; k++) begin
            step(0, 1, 1, 0, I_REF);
            check("scan_ch", ch, k % 13);
            check("scan_wrap", wrap, (k % 13 == 12) ? 1 : 0);
            check("scan_vld", vld, 1);
        end

        step(0, 1, 1, 0, I_REF);
        check("gap_pre_ch", ch, 2);
        step(0, 0, 1, 0, ~I_REF);
        check("gap_vld", vld, 0);
        check("gap_ch", ch, 2);
        check("gap_o", o, I_REF[2]);
        step(0, 0, 1, 0, ~I_REF);
        check("gap2_ch", ch, 2);
        step(0, 1, 1, 0, I_REF);
        check("gap_resume_ch", ch, 3);

        step(1, 0, 0, 0, I_REF);
        for (int k = 0; k < 6; k++) step(0, 1, 1, 0, I_REF);
        check("reentry_pre_ch", ch, 5);
        step(0, 1, 0, 3, I_REF);
        check("reentry_direct_o", o, 1);
        step(0, 1, 0, 3, I_REF);
        step(0, 1, 1, 0, I_REF);
        check("reentry_ch", ch, 0);

        for (int k = 0; k < 9; k++) step(0, 1, 1, 0, I_REF);
        check("midrst_pre_ch", ch, 9);
        step(1, 1, 1, 0, I_REF);
        check("midrst_ch", ch, 0);
        check("midrst_o", o, 0);
        check("midrst_vld", vld, 0);
        step(0, 1, 1, 0, I_REF);
        check("midrst_restart_ch", ch, 0);

        for (int k = 0; k < 1500; k++) begin
            r = ($urandom_range(63) == 0);
            m = ($urandom_range(7) == 0) ? !mode : mode;
            e = ($urandom_range(3) != 0) || (m && !m_prev);
            step(r, e, m, $urandom_range(15), 13'($urandom));
        end

        step4(1, 1, 1, 0);
        check("n4_reset_o", o4, 0);
        for (int k = 0; k < 5; k++) begin
            step4(0, 1, 1, 0);
            check("n4_scan_o", o4, (k % 4 == 0) ? 8'hAA : (k % 4 == 1) ? 8'hBB : (k % 4 == 2) ? 8'hCC : 8'hDD);
            check("n4_scan_wrap", wrap4, (k == 3) ? 1 : 0);
        end
        step4(0, 1, 0, 3);
        check("n4_direct_o", o4, 8'hDD);
        check("n4_direct_err", err4, 0);
        check("n4_direct_vld", vld4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
